// File: rtl/ddr_port_arbiter.sv
// Two-requester arbiter for one MCB user command port: read priority, write FIFO gating.
// Optional starvation guard for the write path is built when ARB_STARVE_GUARD_EN is defined.
module ddr_port_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [5:0]        rd_bl,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [5:0]        wr_bl,
  output logic              wr_ack,
  input  logic [6:0]        wr_count,
  input  logic              cmd_full,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  output logic              busy
);

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    IDLE     = 2'd1,
    ISSUE    = 2'd2
  } state_t;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  state_t     state;
  logic       owner_wr;
  logic       in_arb;
  logic [6:0] wr_need;
  logic       rd_elig;
  logic       wr_elig;
  logic       force_wr;
  logic       grant_rd;
  logic       grant_wr;

  // A write may only go once its whole burst already sits in the write FIFO.
  assign wr_need  = {1'b0, wr_bl} + 7'd1;
  assign rd_elig  = rd_req;
  assign wr_elig  = wr_req && (wr_count >= wr_need);
  assign in_arb   = (state == IDLE) && mem_calib_done;
  assign grant_rd = in_arb && rd_elig && !force_wr;
  assign grant_wr = in_arb && wr_elig && !grant_rd;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  assign force_wr = wr_elig && (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (grant_wr) begin
      starve_cnt <= 8'd0;
    end else if (grant_rd && wr_elig && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_CAL;
      owner_wr      <= 1'b0;
      cmd_instr     <= INSTR_RD;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= '0;
    end else begin
      unique case (state)
        WAIT_CAL: begin
          if (mem_calib_done) state <= IDLE;
        end
        IDLE: begin
          unique case (1'b1)
            !mem_calib_done: state <= WAIT_CAL;
            grant_rd: begin
              state         <= ISSUE;
              owner_wr      <= 1'b0;
              cmd_instr     <= INSTR_RD;
              cmd_bl        <= rd_bl;
              cmd_byte_addr <= rd_addr;
            end
            grant_wr: begin
              state         <= ISSUE;
              owner_wr      <= 1'b1;
              cmd_instr     <= INSTR_WR;
              cmd_bl        <= wr_bl;
              cmd_byte_addr <= wr_addr;
            end
            default: state <= IDLE;
          endcase
        end
        ISSUE: begin
          if (!cmd_full) state <= IDLE;
        end
        default: state <= WAIT_CAL;
      endcase
    end
  end

  assign busy   = (state == ISSUE);
  assign cmd_en = busy && !cmd_full;
  assign rd_ack = cmd_en && !owner_wr;
  assign wr_ack = cmd_en && owner_wr;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: calibration gate, write gating,
// backpressure, starvation guard and reset during ISSUE.
module tb_ddr_port_arbiter;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_calib_done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [5:0]    rd_bl;
  logic          rd_ack;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_bl;
  logic          wr_ack;
  logic [6:0]    wr_count;
  logic          cmd_full;
  logic          cmd_en;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_byte_addr;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  ddr_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(8)) dut (
    .clk(clk),
    .reset(reset),
    .mem_calib_done(mem_calib_done),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_bl(rd_bl),
    .rd_ack(rd_ack),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_bl(wr_bl),
    .wr_ack(wr_ack),
    .wr_count(wr_count),
    .cmd_full(cmd_full),
    .cmd_en(cmd_en),
    .cmd_instr(cmd_instr),
    .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_calib_done = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_bl = '0;
    wr_req = 1'b0; wr_addr = '0; wr_bl = '0;
    wr_count = '0; cmd_full = 1'b0;
    tick(); tick();
    mid();
    n_cmp++; if ({cmd_en, rd_ack, wr_ack, busy} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctl en/rack/wack/busy=%b want 0000", {cmd_en, rd_ack, wr_ack, busy});
    end
    n_cmp++; if (cmd_instr !== 3'b001) begin
      n_err++; $display("FAIL reset_instr got %b want 001", cmd_instr);
    end
    n_cmp++; if (cmd_bl !== 6'd0 || cmd_byte_addr !== '0) begin
      n_err++; $display("FAIL reset_cmd bl=%0d addr=%h want 0/0", cmd_bl, cmd_byte_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_cal_gate();
    int seen;
    seen = 0;
    rd_req = 1'b1; rd_addr = 30'h100; rd_bl = 6'd7;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (cmd_en || busy) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin
      n_err++; $display("FAIL cal_gate_early got %0d active cycles want 0", seen);
    end
    mem_calib_done = 1'b1;
    mid();
    n_cmp++; if (cmd_en !== 1'b0) begin
      n_err++; $display("FAIL cal_gate_c0 cmd_en=%b want 0", cmd_en);
    end
    tick(); mid();
    n_cmp++; if (cmd_en !== 1'b0) begin
      n_err++; $display("FAIL cal_gate_c1 cmd_en=%b want 0", cmd_en);
    end
    tick(); mid();
    n_cmp++; if ({cmd_en, rd_ack, wr_ack} !== 3'b110) begin
      n_err++; $display("FAIL cal_gate_c2 en/rack/wack=%b want 110", {cmd_en, rd_ack, wr_ack});
    end
    n_cmp++; if (cmd_instr !== 3'b001 || cmd_bl !== 6'd7 || cmd_byte_addr !== 30'h100) begin
      n_err++; $display("FAIL cal_gate_cmd instr=%b bl=%0d addr=%h want 001/7/100", cmd_instr, cmd_bl, cmd_byte_addr);
    end
    tick();
    rd_req = 1'b0;
    mid();
    n_cmp++; if ({cmd_en, busy} !== 2'b00 || cmd_byte_addr !== 30'h100) begin
      n_err++; $display("FAIL cal_gate_hold en/busy=%b addr=%h want 00/100", {cmd_en, busy}, cmd_byte_addr);
    end
  endtask

  task automatic test_write_gating();
    int seen;
    seen = 0;
    tick();
    wr_req = 1'b1; wr_addr = 30'h2000; wr_bl = 6'd15; wr_count = 7'd15;
    for (int i = 0; i < 5; i++) begin
      tick(); mid();
      if (cmd_en || busy) seen++;
    end
    n_cmp++; if (seen != 0) begin
      n_err++; $display("FAIL wr_gate_short got %0d active cycles want 0", seen);
    end
    tick();
    wr_count = 7'd16;
    mid();
    n_cmp++; if (busy !== 1'b0) begin
      n_err++; $display("FAIL wr_gate_idle busy=%b want 0", busy);
    end
    tick(); mid();
    n_cmp++; if ({cmd_en, rd_ack, wr_ack, busy} !== 4'b1011) begin
      n_err++; $display("FAIL wr_gate_ack en/rack/wack/busy=%b want 1011", {cmd_en, rd_ack, wr_ack, busy});
    end
    n_cmp++; if (cmd_instr !== 3'b000 || cmd_bl !== 6'd15 || cmd_byte_addr !== 30'h2000) begin
      n_err++; $display("FAIL wr_gate_cmd instr=%b bl=%0d addr=%h want 000/15/2000", cmd_instr, cmd_bl, cmd_byte_addr);
    end
    tick();
    wr_req = 1'b0; wr_count = 7'd0;
    mid();
    n_cmp++; if ({cmd_en, wr_ack} !== 2'b00) begin
      n_err++; $display("FAIL wr_gate_pulse en/wack=%b want 00", {cmd_en, wr_ack});
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    tick();
    rd_req = 1'b1; rd_addr = 30'h300; rd_bl = 6'd3; cmd_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); mid();
      if (cmd_en || rd_ack || wr_ack || !busy) bad++;
      if (cmd_instr != 3'b001 || cmd_bl != 6'd3 || cmd_byte_addr != 30'h300) bad++;
    end
    n_cmp++; if (bad != 0) begin
      n_err++; $display("FAIL bp_hold got %0d bad samples want 0", bad);
    end
    tick();
    cmd_full = 1'b0;
    mid();
    n_cmp++; if ({cmd_en, rd_ack, wr_ack, busy} !== 4'b1101) begin
      n_err++; $display("FAIL bp_release en/rack/wack/busy=%b want 1101", {cmd_en, rd_ack, wr_ack, busy});
    end
    tick();
    rd_req = 1'b0;
    mid();
    n_cmp++; if ({cmd_en, busy} !== 2'b00) begin
      n_err++; $display("FAIL bp_after en/busy=%b want 00", {cmd_en, busy});
    end
  endtask

  task automatic test_starvation();
    int rd_n, wr_n, rd_before, rd_after, both;
    int exp_before, exp_wr, exp_after;
    rd_n = 0; wr_n = 0; rd_before = -1; rd_after = 0; both = 0;
`ifdef ARB_STARVE_GUARD_EN
    exp_before = 8; exp_wr = 1; exp_after = 6;
`else
    exp_before = -1; exp_wr = 0; exp_after = 0;
`endif
    tick();
    rd_req = 1'b1; rd_addr = 30'h400; rd_bl = 6'd1;
    wr_req = 1'b1; wr_addr = 30'h800; wr_bl = 6'd3; wr_count = 7'd64;
    for (int i = 0; i < 30; i++) begin
      tick(); mid();
      if (rd_ack && wr_ack) both++;
      if (rd_ack) begin
        rd_n++;
        if (wr_n > 0) rd_after++;
      end
      if (wr_ack) begin
        if (wr_n == 0) rd_before = rd_n;
        wr_n++;
      end
    end
    n_cmp++; if (wr_n != exp_wr) begin
      n_err++; $display("FAIL starve_wr got %0d wr_acks want %0d", wr_n, exp_wr);
    end
    n_cmp++; if (rd_before != exp_before) begin
      n_err++; $display("FAIL starve_rd_before got %0d want %0d", rd_before, exp_before);
    end
    n_cmp++; if (rd_after != exp_after) begin
      n_err++; $display("FAIL starve_rd_after got %0d want %0d", rd_after, exp_after);
    end
    n_cmp++; if (rd_n + wr_n != 15 || both != 0) begin
      n_err++; $display("FAIL starve_total got %0d acks, %0d dual want 15/0", rd_n + wr_n, both);
    end
    tick();
    rd_req = 1'b0; wr_req = 1'b0; wr_count = 7'd0;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    int bad;
    bad = 0;
    rd_req = 1'b1; rd_addr = 30'h555; rd_bl = 6'd9; cmd_full = 1'b1;
    tick(); mid();
    n_cmp++; if ({busy, cmd_en} !== 2'b10) begin
      n_err++; $display("FAIL rst_issue_pre busy/en=%b want 10", {busy, cmd_en});
    end
    tick();
    reset = 1'b1;
    tick(); mid();
    n_cmp++; if ({cmd_en, rd_ack, wr_ack, busy} !== 4'b0000) begin
      n_err++; $display("FAIL rst_issue_ctl en/rack/wack/busy=%b want 0000", {cmd_en, rd_ack, wr_ack, busy});
    end
    n_cmp++; if (cmd_instr !== 3'b001 || cmd_bl !== 6'd0 || cmd_byte_addr !== '0) begin
      n_err++; $display("FAIL rst_issue_cmd instr=%b bl=%0d addr=%h want 001/0/0", cmd_instr, cmd_bl, cmd_byte_addr);
    end
    cmd_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); mid();
      if (cmd_en || rd_ack || wr_ack || busy) bad++;
    end
    n_cmp++; if (bad != 0) begin
      n_err++; $display("FAIL rst_issue_quiet got %0d bad samples want 0", bad);
    end
    tick();
    reset = 1'b0;
    rd_addr = 30'h666;
    tick(); mid();
    n_cmp++; if (cmd_en !== 1'b0) begin
      n_err++; $display("FAIL rst_issue_waitcal cmd_en=%b want 0", cmd_en);
    end
    tick(); mid();
    n_cmp++; if ({cmd_en, rd_ack} !== 2'b11 || cmd_byte_addr !== 30'h666) begin
      n_err++; $display("FAIL rst_issue_resume en/rack=%b addr=%h want 11/666", {cmd_en, rd_ack}, cmd_byte_addr);
    end
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cal_gate();
    test_write_gating();
    test_backpressure();
    test_starvation();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Shares a single MCB user-port command interface between two requesters: the display read path (scan-out line fetches) and the render write path (Mandelbrot point bursts). The arbiter gives reads priority and bounds how long writes can be starved. It holds back a write until its burst data is already in the MCB write FIFO, and issues exactly one `cmd_en` pulse per granted command. It sits between the port controllers and `videoRam`, and frees one MCB port for other use.

## Interface
- `ADDR_W`, 30, byte-address width, matching the MCB `cmd_byte_addr`.
- `STARVE_LIMIT`, 8, maximum number of consecutive read grants while a write is eligible (range 1–255).
- `clk`  in  1  port clock, the same clock as the MCB port it drives.
- `reset`  in  1  synchronous, active-high reset. Samples only on the rising edge of `clk`.
- `mem_calib_done`  in  1  MCB calibration complete.
- `rd_req`  in  1  read requester has a command pending.
- `rd_addr`  in  ADDR_W  read byte address.
- `rd_bl`  in  6  read burst length minus 1.
- `rd_ack`  out  1  one-cycle pulse: the read command was issued this cycle.
- `wr_req`  in  1  write requester has a command pending.
- `wr_addr`  in  ADDR_W  write byte address.
- `wr_bl`  in  6  write burst length minus 1.
- `wr_ack`  out  1  one-cycle pulse: the write command was issued this cycle.
- `wr_count`  in  7  MCB write-FIFO occupancy, in words.
- `cmd_full`  in  1  MCB command FIFO full.
- `cmd_en`  out  1  MCB command strobe.
- `cmd_instr`  out  3  `3'b000` for write, `3'b001` for read.
- `cmd_bl`  out  6  burst length minus 1.
- `cmd_byte_addr`  out  ADDR_W  command address.
- `busy`  out  1  high whenever the state is ISSUE.

## Operation
- **States.** WAIT_CAL, IDLE and ISSUE.
- **WAIT_CAL.** The arbiter stays here until `mem_calib_done` is 1, then moves to IDLE. All requests are ignored.
- **IDLE.**
  - If `mem_calib_done` is 0, move to WAIT_CAL.
  - Otherwise evaluate eligibility:
    - read eligible = `rd_req`.
    - write eligible = `wr_req` && (`wr_count` >= `wr_bl` + 1). Compare using 7-bit zero-extended `wr_bl`.
  - Grant rule:
    - Grant the read if read eligible, unless the starvation guard forces a write.
    - Otherwise grant the write if write eligible.
    - If neither is eligible, stay in IDLE.
  - On a grant, latch `cmd_instr`, `cmd_bl`, `cmd_byte_addr` and the grant owner, then move to ISSUE.
- **ISSUE.**
  - `cmd_en` = !`cmd_full` (combinational from state and `cmd_full`).
  - When `cmd_en` is 1:
    - the owner's ack is 1 in the same cycle;
    - next state is IDLE.
  - When `cmd_full` is 1, hold in ISSUE with the outputs stable.
  - `mem_calib_done` is not sampled in ISSUE.
- **Starvation counter (8 bits).**
  - Increments on a read grant made while a write was eligible.
  - Clears to 0 on any write grant.
  - Otherwise holds.
  - The guard forces a write when count == `STARVE_LIMIT` and a write is eligible.
  - The counter saturates at `STARVE_LIMIT`.
- **Requester contract.**
  - Hold `req`, `addr` and `bl` stable until ack.
  - The new command (or `req` low) appears in the cycle after ack.
- **Command outputs when not in ISSUE.** `cmd_instr`, `cmd_bl` and `cmd_byte_addr` hold their last latched value.

## Timing
- **Reset values.**
  - state = WAIT_CAL.
  - `cmd_en`, `rd_ack`, `wr_ack`, `busy` = 0.
  - `cmd_instr` = `3'b001`, `cmd_bl` = 0, `cmd_byte_addr` = 0.
  - Starvation count = 0.
- **Latency.** A request sampled in IDLE at cycle N gives `cmd_en` and ack at cycle N+1, provided `cmd_full` is 0.
- **Throughput.** At most one command every 2 cycles.
- **Reset mid-ISSUE.** The latched command is discarded. `cmd_en` is 0 from the first cycle after the reset edge, and no ack is produced.
- **Simultaneous eligible requests.** The read wins unless the guard fires. There is never more than one ack per cycle.
- **`wr_count` changes.** A change of `wr_count` during ISSUE has no effect; eligibility is decided only in IDLE.

## Configuration
- `ARB_STARVE_GUARD_EN`.
- **Defined.** The starvation counter and the forced-write rule are built as described above.
- **Undefined.** The counter is removed and arbitration is strict read priority. `STARVE_LIMIT` is ignored, and writes are granted only in IDLE cycles with no `rd_req`.

## Test plan
- **Calibration gate.** Drive `rd_req`=1 with `mem_calib_done`=0 for 20 cycles, then set `mem_calib_done`=1.
  - No `cmd_en` before calibration.
  - `cmd_en` appears exactly 2 cycles after `mem_calib_done` rises, with `cmd_instr`=001.
- **Write gating.** `wr_req`=1, `wr_bl`=15, `wr_count`=15, then `wr_count`=16.
  - No grant while `wr_count`=15.
  - Grant in the cycle `wr_count`=16 is seen, then `cmd_en` with instr=000, bl=15, and a `wr_ack` pulse.
- **Backpressure.** Hold `cmd_full`=1 for 5 cycles during ISSUE.
  - `cmd_en`=0, `busy`=1, outputs stable.
  - `cmd_en` and ack occur in the single cycle `cmd_full` drops.
- **Starvation (macro defined, `STARVE_LIMIT`=8).** Continuous `rd_req` plus an eligible write.
  - Exactly 8 `rd_ack` pulses, then 1 `wr_ack`, then the reads resume.
  - Without the macro, 0 `wr_ack`.
- **Reset mid-ISSUE.** Assert `reset` during ISSUE with `cmd_full`=1.
  - `cmd_en`, `rd_ack`, `wr_ack` stay 0.
  - State returns to WAIT_CAL and outputs return to their reset values.
